seven_seg_reader: RTL and testbench

Snoops a multiplexed, active-low seven-segment display bus (segment lines plus active-low digit selects) and recovers the hex nibble shown on each digit. Each pattern is filtered for stability and decoded against the team's standard glyph set. The result is held in a per-digit readback register, and every change is emitted on a one-deep valid/ready event port. The block sits beside the display driver for self-check and for readback of display state by test firmware.

---
 rtl/seven_seg_reader.sv | 234 +++++++++++++++++++++++
 tb/tb_seven_seg_reader.sv | 239 +++++++++++++++++++++++
 2 files changed

// File: rtl/seven_seg_reader.sv
// Snoops a multiplexed active-low seven-segment bus and recovers the hex nibble per digit.
// Optional error-capture counter (errCount port) enabled by defining SEVEN_SEG_READER_ERRCNT_EN.
module seven_seg_reader #(
    parameter int NUM_DIGITS    = 4,
    parameter int STABLE_CYCLES = 4
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic [6:0]              segIn,
    input  logic [NUM_DIGITS-1:0]   digitSel,
    output logic                    evValid,
    input  logic                    evReady,
    output logic [2:0]              evDigit,
    output logic [3:0]              evNibble,
    output logic                    evBlank,
    output logic                    evErr,
    output logic [4*NUM_DIGITS-1:0] hexOut,
    output logic [NUM_DIGITS-1:0]   digitValid,
    output logic [NUM_DIGITS-1:0]   digitBlank,
    output logic [NUM_DIGITS-1:0]   digitErr,
    output logic                    overflow,
    input  logic                    clrOvf
`ifdef SEVEN_SEG_READER_ERRCNT_EN
    ,
    output logic [7:0]              errCount
`endif
);

    // state  | meaning
    // IDLE   | digit selects not one-hot, nothing to track
    // SETTLE | counting consecutive identical samples
    // LOCKED | pattern captured, waiting for the next change

    localparam int SW = NUM_DIGITS + 7;
    localparam logic [7:0] STABLE_C = 8'(STABLE_CYCLES);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_SETTLE,
        ST_LOCKED
    } state_t;

    state_t                  state_q, state_d;
    logic [SW-1:0]           sample_q, prev_q;
    logic [7:0]              cnt_q, cnt_d;
    logic [4*NUM_DIGITS-1:0] hex_q, hex_d;
    logic [NUM_DIGITS-1:0]   valid_q, valid_d;
    logic [NUM_DIGITS-1:0]   blank_q, blank_d;
    logic [NUM_DIGITS-1:0]   err_q, err_d;
    logic                    ev_valid_q, ev_valid_d;
    logic [2:0]              ev_digit_q, ev_digit_d;
    logic [3:0]              ev_nib_q, ev_nib_d;
    logic                    ev_blank_q, ev_blank_d;
    logic                    ev_err_q, ev_err_d;
    logic                    ovf_q, ovf_d;

    logic [NUM_DIGITS-1:0]   sel_hi, sel_m1;
    logic                    one_hot;
    logic [2:0]              sel_idx;
    logic                    capture;
    logic                    new_ev;
    logic [3:0]              dec_nib;
    logic                    dec_blank, dec_err;

    function automatic logic [5:0] decode(input logic [6:0] seg);
        logic [5:0] r;
        r = 6'b10_0000;
        case (seg)
            7'h40: r = 6'h00;
            7'h79: r = 6'h01;
            7'h24: r = 6'h02;
            7'h30: r = 6'h03;
            7'h19: r = 6'h04;
            7'h12: r = 6'h05;
            7'h02: r = 6'h06;
            7'h58: r = 6'h07;
            7'h00: r = 6'h08;
            7'h18: r = 6'h09;
            7'h08: r = 6'h0A;
            7'h03: r = 6'h0B;
            7'h46: r = 6'h0C;
            7'h21: r = 6'h0D;
            7'h06: r = 6'h0E;
            7'h0E: r = 6'h0F;
            7'h7F: r = 6'b01_0000;
            default: r = 6'b10_0000;
        endcase
        return r;
    endfunction

    always_comb begin
        sel_hi  = ~sample_q[SW-1:7];
        sel_m1  = sel_hi - NUM_DIGITS'(1);
        one_hot = (sel_hi != '0) && ((sel_hi & sel_m1) == '0);
        sel_idx = 3'd0;
        for (int i = 0; i < NUM_DIGITS; i++) begin
            if (sel_hi[i]) sel_idx = 3'(i);
        end
        {dec_err, dec_blank, dec_nib} = decode(sample_q[6:0]);
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        capture = 1'b0;
        if (!one_hot) begin
            state_d = ST_IDLE;
            cnt_d   = 8'd0;
        end else if (sample_q != prev_q) begin
            state_d = ST_SETTLE;
            cnt_d   = 8'd1;
            if (STABLE_C == 8'd1) begin
                capture = 1'b1;
                state_d = ST_LOCKED;
            end
        end else if (state_q == ST_SETTLE) begin
            cnt_d = cnt_q + 8'd1;
            if (cnt_d == STABLE_C) begin
                capture = 1'b1;
                state_d = ST_LOCKED;
            end
        end
    end

    // Only a good nibble overwrites hexOut; blank/error keep the last good value.
    always_comb begin
        hex_d   = hex_q;
        valid_d = valid_q;
        blank_d = blank_q;
        err_d   = err_q;
        new_ev  = 1'b0;
        for (int i = 0; i < NUM_DIGITS; i++) begin
            if (capture && sel_hi[i]) begin
                if (!valid_q[i] || blank_q[i] != dec_blank || err_q[i] != dec_err ||
                    (!dec_blank && !dec_err && hex_q[4*i +: 4] != dec_nib)) begin
                    new_ev = 1'b1;
                end
                valid_d[i] = 1'b1;
                blank_d[i] = dec_blank;
                err_d[i]   = dec_err;
                if (!dec_blank && !dec_err) hex_d[4*i +: 4] = dec_nib;
            end
        end
    end

    always_comb begin
        ev_valid_d = ev_valid_q;
        ev_digit_d = ev_digit_q;
        ev_nib_d   = ev_nib_q;
        ev_blank_d = ev_blank_q;
        ev_err_d   = ev_err_q;
        ovf_d      = ovf_q;
        if (clrOvf) ovf_d = 1'b0;
        if (ev_valid_q && evReady) ev_valid_d = 1'b0;
        if (new_ev) begin
            if (!ev_valid_q || evReady) begin
                ev_valid_d = 1'b1;
                ev_digit_d = sel_idx;
                ev_nib_d   = (dec_blank || dec_err) ? 4'd0 : dec_nib;
                ev_blank_d = dec_blank;
                ev_err_d   = dec_err;
            end else begin
                ovf_d = 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= ST_IDLE;
            sample_q   <= '0;
            prev_q     <= '0;
            cnt_q      <= 8'd0;
            hex_q      <= '0;
            valid_q    <= '0;
            blank_q    <= '0;
            err_q      <= '0;
            ev_valid_q <= 1'b0;
            ev_digit_q <= 3'd0;
            ev_nib_q   <= 4'd0;
            ev_blank_q <= 1'b0;
            ev_err_q   <= 1'b0;
            ovf_q      <= 1'b0;
        end else begin
            state_q    <= state_d;
            sample_q   <= {digitSel, segIn};
            prev_q     <= sample_q;
            cnt_q      <= cnt_d;
            hex_q      <= hex_d;
            valid_q    <= valid_d;
            blank_q    <= blank_d;
            err_q      <= err_d;
            ev_valid_q <= ev_valid_d;
            ev_digit_q <= ev_digit_d;
            ev_nib_q   <= ev_nib_d;
            ev_blank_q <= ev_blank_d;
            ev_err_q   <= ev_err_d;
            ovf_q      <= ovf_d;
        end
    end

`ifdef SEVEN_SEG_READER_ERRCNT_EN
    logic [7:0] err_cnt_q, err_cnt_d;

    // Counts every error capture, including repeats that raise no event.
    always_comb begin
        err_cnt_d = err_cnt_q;
        if (clrOvf) begin
            err_cnt_d = 8'd0;
        end else if (capture && dec_err && err_cnt_q != 8'hFF) begin
            err_cnt_d = err_cnt_q + 8'd1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) err_cnt_q <= 8'd0;
        else        err_cnt_q <= err_cnt_d;
    end

    assign errCount = err_cnt_q;
`endif

    assign evValid    = ev_valid_q;
    assign evDigit    = ev_digit_q;
    assign evNibble   = ev_nib_q;
    assign evBlank    = ev_blank_q;
    assign evErr      = ev_err_q;
    assign hexOut     = hex_q;
    assign digitValid = valid_q;
    assign digitBlank = blank_q;
    assign digitErr   = err_q;
    assign overflow   = ovf_q;

endmodule

// File: tb/tb_seven_seg_reader.sv
// Directed scoreboard bench for seven_seg_reader; expected events are queued at stimulus time.
module tb_seven_seg_reader;

    logic        clk;
    logic        rst_n;
    logic [6:0]  segIn;
    logic [3:0]  digitSel;
    logic        evValid;
    logic        evReady;
    logic [2:0]  evDigit;
    logic [3:0]  evNibble;
    logic        evBlank;
    logic        evErr;
    logic [15:0] hexOut;
    logic [3:0]  digitValid;
    logic [3:0]  digitBlank;
    logic [3:0]  digitErr;
    logic        overflow;
    logic        clrOvf;
`ifdef SEVEN_SEG_READER_ERRCNT_EN
    logic [7:0]  errCount;
`endif

    seven_seg_reader #(.NUM_DIGITS(4), .STABLE_CYCLES(4)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .segIn      (segIn),
        .digitSel   (digitSel),
        .evValid    (evValid),
        .evReady    (evReady),
        .evDigit    (evDigit),
        .evNibble   (evNibble),
        .evBlank    (evBlank),
        .evErr      (evErr),
        .hexOut     (hexOut),
        .digitValid (digitValid),
        .digitBlank (digitBlank),
        .digitErr   (digitErr),
        .overflow   (overflow),
        .clrOvf     (clrOvf)
`ifdef SEVEN_SEG_READER_ERRCNT_EN
        ,
        .errCount   (errCount)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [2:0] dig;
        logic [3:0] nib;
        logic       blank;
        logic       err;
    } ev_t;

    ev_t q[$];
    int  n_checks = 0;
    int  n_pass   = 0;
    int  n_fail   = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) n_pass++;
        else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic step(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic push_ev(input logic [2:0] d, input logic [3:0] n, input logic b, input logic e);
        ev_t x;
        x.dig = d; x.nib = n; x.blank = b; x.err = e;
        q.push_back(x);
    endtask

    task automatic expect_event(input string tag);
        int   n;
        logic rdy;
        ev_t  x;
        n = 0;
        while (evValid !== 1'b1 && n < 40) begin
            @(negedge clk);
            n++;
        end
        check({tag, "_arrive"}, 32'(evValid), 32'd1);
        if (evValid === 1'b1) begin
            check({tag, "_queued"}, 32'(q.size() != 0), 32'd1);
            if (q.size() != 0) begin
                x = q.pop_front();
                check({tag, "_digit"},  32'(evDigit),  32'(x.dig));
                check({tag, "_nibble"}, 32'(evNibble), 32'(x.nib));
                check({tag, "_blank"},  32'(evBlank),  32'(x.blank));
                check({tag, "_err"},    32'(evErr),    32'(x.err));
            end
            rdy     = evReady;
            evReady = 1'b1;
            @(negedge clk);
            evReady = rdy;
        end
    endtask

    initial begin
        rst_n    = 1'b0;
        segIn    = 7'h7F;
        digitSel = 4'b1111;
        evReady  = 1'b0;
        clrOvf   = 1'b0;
        step(2);
        rst_n = 1'b1;
        step(2);

        check("rst_evValid",    32'(evValid),    32'd0);
        check("rst_hexOut",     32'(hexOut),     32'd0);
        check("rst_digitValid", 32'(digitValid), 32'd0);
        check("rst_overflow",   32'(overflow),   32'd0);
        check("rst_evNibble",   32'(evNibble),   32'd0);
`ifdef SEVEN_SEG_READER_ERRCNT_EN
        check("rst_errCount",   32'(errCount),   32'd0);
`endif

        // Latency: pattern before edge 1, visible after edge 5.
        digitSel = 4'b1110;
        segIn    = 7'h30;
        push_ev(3'd0, 4'h3, 1'b0, 1'b0);
        step(4);
        check("lat_no_ev_e4",  32'(evValid), 32'd0);
        check("lat_no_hex_e4", 32'(hexOut[3:0]), 32'd0);
        step(1);
        check("lat_ev_e5",     32'(evValid), 32'd1);
        check("lat_hex_e5",    32'(hexOut[3:0]), 32'd3);
        check("lat_dvalid_e5", 32'(digitValid), 32'b0001);
        expect_event("t1");
        check("t1_drained", 32'(evValid), 32'd0);

        // Unstable toggling must never capture.
        for (int k = 0; k < 6; k++) begin
            segIn = k[0] ? 7'h02 : 7'h12;
            step(2);
            check("tog_no_ev", 32'(evValid), 32'd0);
        end
        // Back to the stored value: recapture with no event.
        segIn = 7'h30;
        step(8);
        check("tog_final_no_ev", 32'(evValid), 32'd0);
        check("tog_hex_kept",    32'(hexOut[3:0]), 32'd3);

        // Digit 2: good, blank, error.
        evReady  = 1'b1;
        digitSel = 4'b1011;
        segIn    = 7'h0E;
        push_ev(3'd2, 4'hF, 1'b0, 1'b0);
        expect_event("t3_F");
        check("t3_hex_F", 32'(hexOut[11:8]), 32'hF);
        segIn = 7'h7F;
        push_ev(3'd2, 4'h0, 1'b1, 1'b0);
        expect_event("t3_blank");
        check("t3_hex_blank", 32'(hexOut[11:8]), 32'hF);
        check("t3_dblank",    32'(digitBlank[2]), 32'd1);
        segIn = 7'h49;
        push_ev(3'd2, 4'h0, 1'b0, 1'b1);
        expect_event("t3_err");
        check("t3_hex_err", 32'(hexOut[11:8]), 32'hF);
        check("t3_derr",    32'(digitErr[2]), 32'd1);
        check("t3_dblank0", 32'(digitBlank[2]), 32'd0);

        // Overflow: second event dropped while first pending.
        evReady  = 1'b0;
        step(2);
        digitSel = 4'b1101;
        segIn    = 7'h24;
        push_ev(3'd1, 4'h2, 1'b0, 1'b0);
        step(7);
        check("t4_pending", 32'(evValid), 32'd1);
        check("t4_ovf0",    32'(overflow), 32'd0);
        digitSel = 4'b0111;
        segIn    = 7'h21;
        step(7);
        check("t4_ovf1",     32'(overflow), 32'd1);
        check("t4_hex3",     32'(hexOut[15:12]), 32'hD);
        check("t4_held_nib", 32'(evNibble), 32'h2);
        check("t4_held_dig", 32'(evDigit), 32'd1);
        check("t4_dvalid",   32'(digitValid), 32'b1111);
        expect_event("t4");
        check("t4_dropped", 32'(evValid), 32'd0);
        clrOvf = 1'b1;
        step(1);
        clrOvf = 1'b0;
        check("t4_clr", 32'(overflow), 32'd0);

        // Non-one-hot selects never capture; reset kills a pending event.
        digitSel = 4'b1100;
        segIn    = 7'h00;
        for (int k = 0; k < 4; k++) begin
            step(2);
            check("t5_idle_no_ev", 32'(evValid), 32'd0);
        end
        digitSel = 4'b1110;
        segIn    = 7'h19;
        step(7);
        check("t5_pending", 32'(evValid), 32'd1);
        check("t5_hex0",    32'(hexOut[3:0]), 32'h4);
        rst_n = 1'b0;
        #1;
        check("t5_rst_ev",     32'(evValid), 32'd0);
        check("t5_rst_hex",    32'(hexOut), 32'd0);
        check("t5_rst_dvalid", 32'(digitValid), 32'd0);
        q.delete();
        step(2);
        rst_n = 1'b1;
        digitSel = 4'b1111;
        step(8);
        check("t5_after_rst", 32'(evValid), 32'd0);

`ifdef SEVEN_SEG_READER_ERRCNT_EN
        evReady = 1'b1;
        for (int k = 0; k < 300; k++) begin
            digitSel = k[0] ? 4'b1101 : 4'b1110;
            segIn    = 7'h49;
            step(6);
            if (k == 2) check("t6_cnt3", 32'(errCount), 32'd3);
        end
        check("t6_sat", 32'(errCount), 32'd255);
        clrOvf = 1'b1;
        step(1);
        clrOvf = 1'b0;
        check("t6_clr", 32'(errCount), 32'd0);
`endif

        check("queue_empty", 32'(q.size()), 32'd0);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
